// File: rtl/heartbeat_pkg.sv
// Shared definitions for the heartbeat beacon: FSM state encoding and frame constants.
package heartbeat_pkg;

    // Sync word length in bits; the word itself is a parameter of heartbeat_frame.
    localparam int unsigned PREAMBLE_LEN = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PAY,
        ST_PAR,
        ST_GAP
    } hb_state_t;

    // Bits needed for a bit index that must count through the preamble,
    // the payload and the gap, whichever is longest.
    function automatic int unsigned idx_width(input int unsigned width,
                                              input int unsigned gap_bits);
        int unsigned longest;
        longest = PREAMBLE_LEN;
        if (width > longest) begin
            longest = width;
        end
        if (gap_bits > longest) begin
            longest = gap_bits;
        end
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/heartbeat_bit_timer.sv
// Manchester bit timer: divides clk into half-bits of DIV clocks and tracks
// which half of the current bit is on the line.
module heartbeat_bit_timer #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase,
    output logic half_tick,
    output logic bit_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count clocks within a half-bit and flip the phase at each half-bit boundary;
    // held cleared while the frame logic is idle so every frame starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign half_tick = run && (cnt == LAST);
    assign bit_tick  = half_tick && phase;

endmodule

// File: rtl/heartbeat_frame.sv
// Heartbeat beacon: sends a free-running counter as Manchester-coded frames,
// either framed (preamble, payload, even parity, idle gap) or as a legacy
// back-to-back payload stream.
module heartbeat_frame
    import heartbeat_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIV      = 1,
    parameter logic [7:0]  PREAMBLE = 8'hA5,
    parameter int unsigned GAP_BITS = 2
) (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic mode,
    output logic signal,
    output logic frame_start,
    output logic busy
);

    localparam int unsigned IDX_W = idx_width(WIDTH, GAP_BITS);
    localparam logic [IDX_W-1:0] LAST_PRE = IDX_W'(PREAMBLE_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_PAY = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_GAP = (GAP_BITS == 0) ? '0 : IDX_W'(GAP_BITS - 1);

    hb_state_t        state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             par_bit, par_n;
    logic             mode_lat, mode_n;
    logic             frame_end;
    logic             launch;
    logic             run;
    logic             phase, half_tick, bit_tick;
    logic             phase_n;
    logic             bit_n;
    logic             sig_n;

    assign run = (state != ST_IDLE);

    heartbeat_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .phase     (phase),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    // Next-state, frame-boundary and next-line-value decode.
    // The output is registered, so the line value is computed from the
    // *next* position (state_n/idx_n/phase_n) to keep signal aligned with state.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        count_n   = count;
        shreg_n   = shreg;
        par_n     = par_bit;
        mode_n    = mode_lat;
        frame_end = 1'b0;
        launch    = 1'b0;

        case (state)
            ST_IDLE: begin
                launch = en;
            end
            ST_PRE: begin
                if (bit_tick) begin
                    if (idx == LAST_PRE) begin
                        state_n = ST_PAY;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (bit_tick) begin
                    shreg_n = shreg << 1;
                    if (idx == LAST_PAY) begin
                        if (mode_lat) begin
                            frame_end = 1'b1;
                        end else begin
                            state_n = ST_PAR;
                            idx_n   = '0;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_tick) begin
                    if (GAP_BITS == 0) begin
                        frame_end = 1'b1;
                    end else begin
                        state_n = ST_GAP;
                        idx_n   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (bit_tick) begin
                    if (idx == LAST_GAP) begin
                        frame_end = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
            end
        endcase

        // Frame end: advance the counter, then either chain straight into the
        // next frame (en still high) or drop back to idle; en low wins over mode.
        if (frame_end) begin
            count_n = count + 1'b1;
            launch  = en;
            if (!en) begin
                state_n = ST_IDLE;
                idx_n   = '0;
            end
        end

        // Frame start: sample mode and latch the payload (post-increment value
        // when chaining from a previous frame) together with its parity.
        if (launch) begin
            state_n = mode ? ST_PAY : ST_PRE;
            idx_n   = '0;
            mode_n  = mode;
            shreg_n = count_n;
            par_n   = ^count_n;
        end

        phase_n = phase ^ half_tick;

        case (state_n)
            ST_PRE:  bit_n = PREAMBLE[3'(LAST_PRE - idx_n)];
            ST_PAY:  bit_n = shreg_n[WIDTH-1];
            ST_PAR:  bit_n = par_n;
            default: bit_n = 1'b0;
        endcase

        // Manchester: first half carries the bit, second half its complement;
        // idle and gap stay flat low.
        if ((state_n == ST_PRE) || (state_n == ST_PAY) || (state_n == ST_PAR)) begin
            sig_n = bit_n ^ phase_n;
        end else begin
            sig_n = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            count       <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            mode_lat    <= 1'b0;
            signal      <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            count       <= count_n;
            shreg       <= shreg_n;
            par_bit     <= par_n;
            mode_lat    <= mode_n;
            signal      <= sig_n;
            frame_start <= launch;
            busy        <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_heartbeat_frame.sv
// Self-checking bench for heartbeat_frame: three parameterisations driven by
// shared inputs, each compared every clock against a frame-level reference model.
module tb_heartbeat_frame;

    localparam int NDUT = 3;

    logic clk;
    logic rst_n;
    logic en;
    logic mode;
    logic sig [NDUT];
    logic fs  [NDUT];
    logic bsy [NDUT];

    heartbeat_frame #(.WIDTH(8), .DIV(1), .PREAMBLE(8'hA5), .GAP_BITS(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .signal(sig[0]), .frame_start(fs[0]), .busy(bsy[0]));

    heartbeat_frame #(.WIDTH(8), .DIV(3), .PREAMBLE(8'hA5), .GAP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .signal(sig[1]), .frame_start(fs[1]), .busy(bsy[1]));

    heartbeat_frame #(.WIDTH(4), .DIV(2), .PREAMBLE(8'h3C), .GAP_BITS(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .signal(sig[2]), .frame_start(fs[2]), .busy(bsy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cfg_width(input int d);
        return (d == 2) ? 4 : 8;
    endfunction
    function automatic int cfg_div(input int d);
        case (d)
            0: return 1;
            1: return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int cfg_gap(input int d);
        return (d == 2) ? 0 : 2;
    endfunction
    function automatic logic [7:0] cfg_pre(input int d);
        return (d == 2) ? 8'h3C : 8'hA5;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected half-clock samples of the frame in flight.
    bit              expq   [NDUT][$];
    longint unsigned mcnt   [NDUT];
    bit              minf   [NDUT];
    bit              e_sig  [NDUT];
    bit              e_fs   [NDUT];
    bit              e_busy [NDUT];

    task automatic check_bit(input string name, input int d, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %b expected %b", name, d, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    task automatic push_bit(input int d, input bit b, input bit quiet);
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < cfg_div(d); k++) begin
                expq[d].push_back(quiet ? 1'b0 : ((h == 0) ? b : ~b));
            end
        end
    endtask

    task automatic push_frame(input int d, input bit legacy);
        logic [7:0]      pre;
        longint unsigned v;
        pre = cfg_pre(d);
        v   = mcnt[d];
        if (!legacy) begin
            for (int i = 7; i >= 0; i--) push_bit(d, pre[i], 1'b0);
        end
        for (int i = cfg_width(d) - 1; i >= 0; i--) push_bit(d, v[i], 1'b0);
        if (!legacy) begin
            push_bit(d, ^v, 1'b0);
            for (int g = 0; g < cfg_gap(d); g++) push_bit(d, 1'b0, 1'b1);
        end
    endtask

    task automatic model_reset(input int d);
        expq[d].delete();
        mcnt[d]   = 0;
        minf[d]   = 1'b0;
        e_sig[d]  = 1'b0;
        e_fs[d]   = 1'b0;
        e_busy[d] = 1'b0;
    endtask

    task automatic model_step(input int d, input bit e, input bit m);
        e_fs[d] = 1'b0;
        if (expq[d].size() > 0) begin
            e_sig[d] = expq[d].pop_front();
        end else begin
            if (minf[d]) begin
                mcnt[d] = (mcnt[d] + 1) % (64'd1 << cfg_width(d));
                minf[d] = 1'b0;
            end
            if (e) begin
                push_frame(d, m);
                e_sig[d] = expq[d].pop_front();
                e_fs[d]  = 1'b1;
                minf[d]  = 1'b1;
            end else begin
                e_sig[d] = 1'b0;
            end
        end
        e_busy[d] = minf[d];
    endtask

    task automatic tick(input bit chk);
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (rst_n !== 1'b1) model_reset(d);
            else model_step(d, en, mode);
        end
        #1;
        if (chk) begin
            for (int d = 0; d < NDUT; d++) begin
                check_bit("signal", d, sig[d], e_sig[d]);
                check_bit("frame_start", d, fs[d], e_fs[d]);
                check_bit("busy", d, bsy[d], e_busy[d]);
            end
        end
    endtask

    task automatic wait_fs(input int d);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            tick(1'b1);
            n++;
            if (fs[d] === 1'b1) seen = 1'b1;
        end
        if (!seen) check_bit("frame_start_timeout", d, fs[d], 1'b1);
    endtask

    task automatic measure_period(input int d, input int exp);
        int n;
        bit seen;
        wait_fs(d);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            tick(1'b1);
            n++;
            if (fs[d] === 1'b1) seen = 1'b1;
        end
        check_int("frame_period", d, n, exp);
    endtask

    // Decode one framed dut0 frame from the line; call just after its frame_start.
    task automatic capture0(output logic [7:0] pay, output logic par);
        logic s [38];
        s[0] = sig[0];
        for (int j = 1; j < 38; j++) begin
            tick(1'b1);
            s[j] = sig[0];
        end
        for (int i = 0; i < 8; i++) pay[7-i] = s[16 + 2*i];
        par = s[32];
    endtask

    typedef struct {
        bit en;
        bit mode;
        bit sig;
        bit fs;
        bit busy;
    } vec_t;

    vec_t        tv [40];
    logic [37:0] golden;
    logic [7:0]  pay;
    logic [7:0]  v;
    logic        par;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // First framed frame of dut0 from reset, counter 0.
        golden = {16'b1001_1001_0110_0110, 16'h5555, 2'b01, 4'b0000};
        for (int i = 0; i < 38; i++) begin
            tv[i] = '{1'b1, 1'b0, golden[37-i], (i == 0), 1'b1};
        end
        tv[38] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[39] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int d = 0; d < NDUT; d++) model_reset(d);
        rst_n = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        #2 rst_n = 1'b0;

        repeat (3) tick(1'b1);
        for (int d = 0; d < NDUT; d++) begin
            check_bit("reset_signal", d, sig[d], 1'b0);
            check_bit("reset_busy", d, bsy[d], 1'b0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            en   = tv[i].en;
            mode = tv[i].mode;
            tick(1'b1);
            check_bit("tbl_signal", 0, sig[0], tv[i].sig);
            check_bit("tbl_frame_start", 0, fs[0], tv[i].fs);
            check_bit("tbl_busy", 0, bsy[0], tv[i].busy);
        end

        // Counter wrap on dut0: frame 255 then frame 0.
        for (int f = 0; f < 254; f++) wait_fs(0);
        capture0(pay, par);
        check_int("wrap_payload_ff", 0, int'(pay), 255);
        check_bit("wrap_parity_ff", 0, par, 1'b0);
        wait_fs(0);
        capture0(pay, par);
        check_int("wrap_payload_00", 0, int'(pay), 0);
        check_bit("wrap_parity_00", 0, par, 1'b0);

        // Framed frame lengths for each parameterisation.
        measure_period(0, 38);
        measure_period(1, 114);
        measure_period(2, 52);

        // Drop en at the 10th clock of a frame: frame completes, then idle.
        wait_fs(0);
        capture0(v, par);
        wait_fs(0);
        repeat (9) tick(1'b1);
        en = 1'b0;
        repeat (130) tick(1'b1);
        for (int d = 0; d < NDUT; d++) check_bit("drop_busy", d, bsy[d], 1'b0);
        repeat (8) begin
            tick(1'b1);
            check_bit("drop_signal_low", 0, sig[0], 1'b0);
        end
        en = 1'b1;
        wait_fs(0);
        capture0(pay, par);
        check_int("resume_payload", 0, int'(pay), int'(8'(v + 8'd2)));
        check_bit("resume_parity", 0, par, ^(8'(v + 8'd2)));

        // Legacy continuous stream.
        mode = 1'b1;
        wait_fs(0);
        wait_fs(0);
        measure_period(0, 16);
        measure_period(1, 48);
        measure_period(2, 16);

        // Reset in the middle of a payload.
        mode = 1'b0;
        wait_fs(0);
        wait_fs(0);
        repeat (20) tick(1'b1);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            model_reset(d);
            check_bit("async_reset_signal", d, sig[d], 1'b0);
            check_bit("async_reset_busy", d, bsy[d], 1'b0);
        end
        repeat (2) tick(1'b1);
        rst_n = 1'b1;
        wait_fs(0);
        capture0(pay, par);
        check_int("post_reset_payload", 0, int'(pay), 0);
        check_bit("post_reset_parity", 0, par, 1'b0);

        // Random en/mode activity, including changes mid-frame and at boundaries.
        repeat (3000) begin
            if ($urandom_range(19) == 0) en = ~en;
            if ($urandom_range(14) == 0) mode = ~mode;
            tick(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
